// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit with req/ack memory handshake and next-PC selection.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  nPC_sel,
  input  logic        j_sel,
  input  logic        zero,
  input  logic        advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired
);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_instr, r_retired, w_next_pc;
  logic        r_valid, w_load, w_retire, w_jump, w_branch;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_state_nxt;
  always_comb begin
    w_load      = 1'b0;
    w_retire    = 1'b0;
    w_state_nxt = r_state;
    if (r_state == FETCH) begin
      w_load      = imem_ack;
      w_state_nxt = imem_ack ? HOLD : FETCH;
    end else begin
      w_retire    = advance;
      w_state_nxt = advance ? FETCH : HOLD;
    end
  end
  // Jump outranks branch; reserved select 11 falls through to sequential.
  assign w_jump    = (nPC_sel == 2'b01) || j_sel;
  assign w_branch  = (nPC_sel == 2'b10) && zero;
  assign pc_plus4  = r_pc + 32'd4;
  assign w_next_pc = w_jump   ? {pc_plus4[31:28], r_instr[25:0], 2'b00} :
                     w_branch ? pc_plus4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00} :
                                pc_plus4;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_valid   <= 1'b0;
      r_retired <= '0;
    end else if (w_load) begin
      r_instr <= imem_rdata;
      r_valid <= 1'b1;
    end else if (w_retire) begin
      r_pc      <= w_next_pc;
      r_valid   <= 1'b0;
      r_retired <= r_retired + 32'd1;
    end
  // Gate with rst_n so the request drops the instant reset asserts.
  assign imem_req    = rst_n && (r_state == FETCH);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instruction = r_instr;
  assign instr_valid = r_valid;
  assign retired     = r_retired;
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed checks of fetch handshake, next-PC selection and reset behaviour.
module tb_ifu_fetch;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic [1:0]  nPC_sel = 2'b00;
  logic        j_sel = 1'b0, zero = 1'b0, advance = 1'b0, imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instruction, pc, pc_plus4, retired;
  logic        w_adv2 = 1'b0, w_req2, w_valid2;
  logic [31:0] w_addr2, w_instr2, w_pc2, w_pc4_2, w_ret2;
  int          n_tests = 0, n_fail = 0;

  ifu_fetch u_dut (
    .clk(clk), .rst_n(rst_n), .nPC_sel(nPC_sel), .j_sel(j_sel), .zero(zero),
    .advance(advance), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instruction(instruction), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .retired(retired)
  );

  ifu_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .nPC_sel(2'b00), .j_sel(1'b0), .zero(1'b0),
    .advance(w_adv2), .imem_req(w_req2), .imem_addr(w_addr2), .imem_ack(1'b1),
    .imem_rdata(32'h0000_0000), .instruction(w_instr2), .instr_valid(w_valid2),
    .pc(w_pc2), .pc_plus4(w_pc4_2), .retired(w_ret2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch one word (zero-wait ack), then retire it with the given select inputs.
  task automatic fetch_retire(input logic [31:0] word, input logic [1:0] sel, input logic j, input logic z);
    imem_ack = 1'b1; imem_rdata = word; advance = 1'b0;
    step();
    chk("fr_valid", {31'd0, instr_valid}, 32'd1);
    chk("fr_instr", instruction, word);
    imem_ack = 1'b0; nPC_sel = sel; j_sel = j; zero = z; advance = 1'b1;
    step();
    advance = 1'b0; nPC_sel = 2'b00; j_sel = 1'b0; zero = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("wrap_pc4", w_pc4_2, 32'h0000_0000);
    step(); step();
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h3C01_1234;
    #1;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0000_3000);
    step();
    chk("zw_valid", {31'd0, instr_valid}, 32'd1);
    chk("zw_instr", instruction, 32'h3C01_1234);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    imem_rdata = 32'hDEAD_BEEF;
    step();
    chk("hold_ack_ign", instruction, 32'h3C01_1234);
    imem_ack = 1'b0; advance = 1'b1;
    step();
    chk("seq_pc", pc, 32'h0000_3004);
    chk("seq_ret", retired, 32'd1);
    chk("seq_valid", {31'd0, instr_valid}, 32'd0);
    chk("seq_pc4", pc_plus4, 32'h0000_3008);
    step();
    advance = 1'b0;
    step();
    advance = 1'b1;
    step();
    chk("wait_req", {31'd0, imem_req}, 32'd1);
    chk("wait_addr", imem_addr, 32'h0000_3004);
    chk("wait_pc", pc, 32'h0000_3004);
    chk("wait_ret", retired, 32'd1);
    chk("wait_instr", instruction, 32'h3C01_1234);
    advance = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h2402_0001;
    step();
    chk("late_instr", instruction, 32'h2402_0001);
    chk("late_valid", {31'd0, instr_valid}, 32'd1);
    imem_ack = 1'b0; advance = 1'b1;
    step();
    advance = 1'b0;
    chk("pc_3008", pc, 32'h0000_3008);
    fetch_retire(32'h1000_FFFE, 2'b10, 1'b0, 1'b1);
    chk("beq_taken", pc, 32'h0000_3004);
    fetch_retire(32'h0000_0000, 2'b11, 1'b0, 1'b1);
    chk("sel11_seq", pc, 32'h0000_3008);
    fetch_retire(32'h1000_FFFE, 2'b10, 1'b0, 1'b0);
    chk("beq_not", pc, 32'h0000_300C);
    fetch_retire(32'h0000_0000, 2'b00, 1'b0, 1'b1);
    chk("pc_3010", pc, 32'h0000_3010);
    fetch_retire(32'h0800_0C00, 2'b01, 1'b1, 1'b0);
    chk("jump", pc, 32'h0000_3000);
    chk("ret7", retired, 32'd7);
    fetch_retire(32'h0800_0C40, 2'b10, 1'b1, 1'b1);
    chk("jump_prio", pc, 32'h0000_3100);
    fetch_retire(32'h1000_0004, 2'b10, 1'b0, 1'b1);
    chk("beq_fwd", pc, 32'h0000_3114);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0; advance = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("mr_instr", instruction, 32'd0);
    chk("mr_valid", {31'd0, instr_valid}, 32'd0);
    chk("mr_req", {31'd0, imem_req}, 32'd0);
    chk("mr_pc", pc, 32'h0000_3000);
    chk("mr_ret", retired, 32'd0);
    step();
    advance = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h0000_3000);
    step();
    chk("post_pc", pc, 32'h0000_3000);
    chk("post_ret", retired, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mf_req", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("wrap_valid", {31'd0, w_valid2}, 32'd1);
    chk("wrap_addr", w_addr2, 32'hFFFF_FFFC);
    w_adv2 = 1'b1;
    step();
    w_adv2 = 1'b0;
    chk("wrap_pc", w_pc2, 32'h0000_0000);
    chk("wrap_ret", w_ret2, 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
